// File: rtl/riscv_mem_pkg.sv
// Shared types and lane helpers for the MEM stage: access sizes, FSM states,
// byte-enable/store-lane generation and alignment checks.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    // Size code 3 is reserved and behaves as a word access everywhere.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return 4'b0011 << addr_lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half/word lane out of a 32-bit read beat and
// sign- or zero-extends it to 32 bits.
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        mem_unsigned,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    assign byte_val = lane[addr_lo];
    assign half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (size)
            SZ_BYTE: result = {{24{byte_val[7] & ~mem_unsigned}}, byte_val};
            SZ_HALF: result = {{16{half_val[15] & ~mem_unsigned}}, half_val};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: registers EX results, resolves branches, runs loads/stores
// over a req/gnt/rvalid port. Optional access timeout via MEM_TIMEOUT_EN.
module memory_access
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic        flag_zero,
    input  logic [31:0] add_pc,
    input  logic [31:0] store_data,
    input  logic        branch,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic        reg_write_in,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_error
);

    mem_state_t  state_reg, state_next;

    logic [31:0] addr_reg;
    logic [1:0]  addr_lo_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [4:0]  rd_reg;
    logic        rw_reg;

    logic        wb_valid_reg, wb_reg_write_reg, misaligned_reg, bus_error_reg;
    logic [4:0]  wb_rd_reg;
    logic [31:0] wb_data_reg;
    logic        pc_src_reg;
    logic [31:0] branch_target_reg;

    logic        accept, is_mem, misalign_in, start_mem, direct_beat;
    logic        done_store, done_load, timeout_hit, timeout_abort;
    logic [31:0] load_result;

    assign stall       = (state_reg != IDLE);
    assign accept      = in_valid && !stall;
    assign is_mem      = mem_read || mem_write;
    assign misalign_in = is_misaligned(mem_size, alu_result[1:0]);
    // Branches win over memory flags; misaligned ops never reach the bus.
    assign start_mem   = accept && !branch && is_mem && !misalign_in;
    assign direct_beat = accept && (branch || !is_mem || misalign_in);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            cnt_reg <= '0;
        end else if (cnt_reg < CNT_W'(TIMEOUT)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // >= rather than == so a load granted on the limit cycle still aborts in WAIT.
    assign timeout_hit = (state_reg != IDLE) && (cnt_reg >= CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        done_store    = 1'b0;
        done_load     = 1'b0;
        timeout_abort = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_mem) state_next = REQ;
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (we_reg) begin
                        state_next = IDLE;
                        done_store = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end else if (timeout_hit) begin
                    state_next    = IDLE;
                    timeout_abort = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_next = IDLE;
                    done_load  = 1'b1;
                end else if (timeout_hit) begin
                    state_next    = IDLE;
                    timeout_abort = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            addr_lo_reg       <= '0;
            be_reg            <= '0;
            wdata_reg         <= '0;
            we_reg            <= 1'b0;
            size_reg          <= '0;
            uns_reg           <= 1'b0;
            rd_reg            <= '0;
            rw_reg            <= 1'b0;
            wb_valid_reg      <= 1'b0;
            wb_reg_write_reg  <= 1'b0;
            wb_rd_reg         <= '0;
            wb_data_reg       <= '0;
            misaligned_reg    <= 1'b0;
            bus_error_reg     <= 1'b0;
            pc_src_reg        <= 1'b0;
            branch_target_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wb_valid_reg <= 1'b0;
            pc_src_reg   <= 1'b0;

            if (start_mem) begin
                addr_reg    <= {alu_result[31:2], 2'b00};
                addr_lo_reg <= alu_result[1:0];
                be_reg      <= byte_enable(mem_size, alu_result[1:0]);
                wdata_reg   <= store_lanes(mem_size, store_data);
                we_reg      <= mem_write;
                size_reg    <= mem_size;
                uns_reg     <= mem_unsigned;
                rd_reg      <= rd_in;
                rw_reg      <= reg_write_in;
            end

            if (direct_beat) begin
                wb_valid_reg     <= 1'b1;
                wb_reg_write_reg <= reg_write_in && !branch && !is_mem;
                wb_rd_reg        <= rd_in;
                wb_data_reg      <= alu_result;
                misaligned_reg   <= !branch && is_mem && misalign_in;
                bus_error_reg    <= 1'b0;
                pc_src_reg       <= branch && flag_zero;
                if (branch) branch_target_reg <= add_pc;
            end

            if (done_store || done_load || timeout_abort) begin
                wb_valid_reg     <= 1'b1;
                wb_reg_write_reg <= done_load && rw_reg;
                wb_rd_reg        <= rd_reg;
                wb_data_reg      <= done_load ? load_result : 32'h0;
                misaligned_reg   <= 1'b0;
                bus_error_reg    <= timeout_abort;
            end
        end
    end

    load_extend u_load_extend (
        .rdata        (dmem_rdata),
        .addr_lo      (addr_lo_reg),
        .size         (size_reg),
        .mem_unsigned (uns_reg),
        .result       (load_result)
    );

    assign dmem_req      = (state_reg == REQ);
    assign dmem_we       = we_reg;
    assign dmem_addr     = addr_reg;
    assign dmem_be       = be_reg;
    assign dmem_wdata    = wdata_reg;
    assign pc_src        = pc_src_reg;
    assign branch_target = branch_target_reg;
    assign wb_valid      = wb_valid_reg;
    assign wb_reg_write  = wb_reg_write_reg;
    assign wb_rd         = wb_rd_reg;
    assign wb_data       = wb_data_reg;
    assign misaligned    = misaligned_reg;
    assign bus_error     = bus_error_reg;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage: ALU/branch beats, store/load lanes,
// misalignment, stall gating and reset in the middle of an access.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, flag_zero, branch, mem_read, mem_write, mem_unsigned, reg_write_in;
    logic [31:0] alu_result, add_pc, store_data, dmem_rdata;
    logic [1:0]  mem_size;
    logic [4:0]  rd_in;
    logic        dmem_gnt, dmem_rvalid;
    logic        stall, pc_src, dmem_req, dmem_we, wb_valid, wb_reg_write, misaligned, bus_error;
    logic [31:0] branch_target, dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } lane_vec_t;

    memory_access dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .flag_zero(flag_zero), .add_pc(add_pc), .store_data(store_data),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .reg_write_in(reg_write_in), .rd_in(rd_in), .stall(stall),
        .pc_src(pc_src), .branch_target(branch_target), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; alu_result = 0; flag_zero = 0; add_pc = 0; store_data = 0;
        branch = 0; mem_read = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0;
        reg_write_in = 0; rd_in = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({stall, pc_src, dmem_req, dmem_we, wb_valid, wb_reg_write, misaligned, bus_error} !== 8'h0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000000", {stall, pc_src, dmem_req, dmem_we, wb_valid, wb_reg_write, misaligned, bus_error}); end
        n_cmp++; if ({dmem_addr, dmem_wdata, wb_data, branch_target, dmem_be, wb_rd} !== 137'h0) begin n_fail++; $display("FAIL reset_buses: addr %h wdata %h wb_data %h tgt %h be %b rd %0d want all 0", dmem_addr, dmem_wdata, wb_data, branch_target, dmem_be, wb_rd); end
        rst = 0;
        step();
        n_cmp++; if (stall !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: stall %b wb_valid %b want 0 0", stall, wb_valid); end
        $display("reset: outputs cleared");
    endtask

    task automatic test_alu();
        in_valid = 1; alu_result = 32'h1234; rd_in = 5; reg_write_in = 1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall_pre: got %b want 0", stall); end
        step();
        clear_inputs();
        n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wb_valid: got %b want 1", wb_valid); end
        n_cmp++; if (wb_data !== 32'h1234) begin n_fail++; $display("FAIL alu_wb_data: got %h want 00001234", wb_data); end
        n_cmp++; if (wb_rd !== 5'd5 || wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL alu_wb_rd: rd %0d rw %b want 5 1", wb_rd, wb_reg_write); end
        n_cmp++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL alu_no_mem: stall %b req %b want 0 0", stall, dmem_req); end
        step();
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_wb_pulse: got %b want 0", wb_valid); end
        $display("alu: alu_result=00001234 rd=5 -> wb_data=%h rd=%0d", 32'h1234, 5);
    endtask

    task automatic test_branch(input logic fz, input logic [31:0] target);
        in_valid = 1; branch = 1; flag_zero = fz; add_pc = target;
        mem_read = 1; mem_size = 2'd2; alu_result = 32'h40; reg_write_in = 1; rd_in = 3;
        step();
        clear_inputs();
        n_cmp++; if (pc_src !== fz) begin n_fail++; $display("FAIL branch_pc_src: got %b want %b", pc_src, fz); end
        n_cmp++; if (branch_target !== target) begin n_fail++; $display("FAIL branch_target: got %h want %h", branch_target, target); end
        n_cmp++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL branch_wb: valid %b rw %b want 1 0", wb_valid, wb_reg_write); end
        n_cmp++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL branch_ignores_mem: stall %b req %b want 0 0", stall, dmem_req); end
        step();
        n_cmp++; if (pc_src !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL branch_pulse: pc_src %b stall %b want 0 0", pc_src, stall); end
        $display("branch: flag_zero=%b add_pc=%h -> pc_src=%b", fz, target, fz);
    endtask

    task automatic test_store_byte();
        in_valid = 1; mem_write = 1; mem_size = 2'd0; alu_result = 32'h103; store_data = 32'hDEAD00AB; rd_in = 4;
        step();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_gnt = 1;
            n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL store_hold_ctl[%0d]: req %b we %b stall %b want 1 1 1", i, dmem_req, dmem_we, stall); end
            n_cmp++; if (dmem_addr !== 32'h100 || dmem_be !== 4'b1000 || dmem_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL store_hold_bus[%0d]: addr %h be %b wdata %h want 00000100 1000 abababab", i, dmem_addr, dmem_be, dmem_wdata); end
            n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL store_early_wb[%0d]: got %b want 0", i, wb_valid); end
            step();
        end
        dmem_gnt = 0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL store_wb: valid %b rw %b want 1 0", wb_valid, wb_reg_write); end
        n_cmp++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL store_done: stall %b req %b want 0 0", stall, dmem_req); end
        step();
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL store_wb_pulse: got %b want 0", wb_valid); end
        $display("store byte: addr=00000103 data=ab gnt after 3 waits");
    endtask

    task automatic test_load_half(input logic uns, input logic [31:0] exp);
        in_valid = 1; mem_read = 1; mem_size = 2'd1; mem_unsigned = uns; alu_result = 32'h202; rd_in = 7; reg_write_in = 1;
        step();
        clear_inputs();
        n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h200 || dmem_be !== 4'b1100) begin n_fail++; $display("FAIL load_req: req %b we %b addr %h be %b want 1 0 00000200 1100", dmem_req, dmem_we, dmem_addr, dmem_be); end
        dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h77777777;
        step();
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        n_cmp++; if (dmem_req !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL load_wait: req %b stall %b wb_valid %b want 0 1 0", dmem_req, stall, wb_valid); end
        step();
        n_cmp++; if (stall !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL load_wait2: stall %b wb_valid %b want 1 0", stall, wb_valid); end
        dmem_rvalid = 1; dmem_rdata = 32'h80010000;
        step();
        dmem_rvalid = 0; dmem_rdata = 0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== exp) begin n_fail++; $display("FAIL load_half_data: valid %b data %h want 1 %h", wb_valid, wb_data, exp); end
        n_cmp++; if (wb_rd !== 5'd7 || wb_reg_write !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL load_half_wb: rd %0d rw %b stall %b want 7 1 0", wb_rd, wb_reg_write, stall); end
        $display("load half: addr=00000202 unsigned=%b rdata=80010000 -> %h", uns, exp);
    endtask

    task automatic test_misaligned(input logic is_store, input logic [1:0] size, input logic [31:0] addr);
        in_valid = 1; mem_read = !is_store; mem_write = is_store; mem_size = size; alu_result = addr; reg_write_in = 1; rd_in = 6;
        step();
        clear_inputs();
        n_cmp++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL misal_no_req: req %b stall %b want 0 0", dmem_req, stall); end
        n_cmp++; if (wb_valid !== 1'b1 || misaligned !== 1'b1 || wb_reg_write !== 1'b0 || bus_error !== 1'b0) begin n_fail++; $display("FAIL misal_wb: valid %b mis %b rw %b berr %b want 1 1 0 0", wb_valid, misaligned, wb_reg_write, bus_error); end
        step();
        n_cmp++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL misal_after: valid %b req %b want 0 0", wb_valid, dmem_req); end
        $display("misaligned: store=%b size=%0d addr=%h flagged", is_store, size, addr);
    endtask

    task automatic test_lanes();
        lane_vec_t vecs [8];
        vecs[0] = '{1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
        vecs[1] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h1234BEEF, 4'b1100, 32'hBEEFBEEF};
        vecs[2] = '{1'b1, 2'd0, 1'b0, 32'h21, 32'h0000005A, 4'b0010, 32'h5A5A5A5A};
        vecs[3] = '{1'b1, 2'd3, 1'b0, 32'h30, 32'h11223344, 4'b1111, 32'h11223344};
        vecs[4] = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h00008000, 4'b0010, 32'hFFFFFF80};
        vecs[5] = '{1'b0, 2'd0, 1'b1, 32'h13, 32'hC5000000, 4'b1000, 32'h000000C5};
        vecs[6] = '{1'b0, 2'd1, 1'b0, 32'h20, 32'hFFFF7FFF, 4'b0011, 32'h00007FFF};
        vecs[7] = '{1'b0, 2'd2, 1'b0, 32'h24, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; mem_write = vecs[i].we; mem_read = !vecs[i].we; mem_size = vecs[i].size;
            mem_unsigned = vecs[i].uns; alu_result = vecs[i].addr; store_data = vecs[i].data;
            reg_write_in = 1; rd_in = 5'(10 + i);
            step();
            clear_inputs();
            n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== vecs[i].we || dmem_be !== vecs[i].be || dmem_addr !== {vecs[i].addr[31:2], 2'b00}) begin n_fail++; $display("FAIL lane_req[%0d]: req %b we %b be %b addr %h want 1 %b %b %h", i, dmem_req, dmem_we, dmem_be, dmem_addr, vecs[i].we, vecs[i].be, {vecs[i].addr[31:2], 2'b00}); end
            if (vecs[i].we) begin
                n_cmp++; if (dmem_wdata !== vecs[i].exp) begin n_fail++; $display("FAIL lane_wdata[%0d]: got %h want %h", i, dmem_wdata, vecs[i].exp); end
            end
            dmem_gnt = 1;
            step();
            dmem_gnt = 0;
            if (!vecs[i].we) begin
                n_cmp++; if (wb_valid !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL lane_wait[%0d]: wb_valid %b stall %b want 0 1", i, wb_valid, stall); end
                dmem_rvalid = 1; dmem_rdata = vecs[i].data;
                step();
                dmem_rvalid = 0; dmem_rdata = 0;
                n_cmp++; if (wb_valid !== 1'b1 || wb_data !== vecs[i].exp || wb_reg_write !== 1'b1 || wb_rd !== 5'(10 + i)) begin n_fail++; $display("FAIL lane_load[%0d]: valid %b data %h rw %b rd %0d want 1 %h 1 %0d", i, wb_valid, wb_data, wb_reg_write, wb_rd, vecs[i].exp, 10 + i); end
            end else begin
                n_cmp++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL lane_store[%0d]: valid %b rw %b stall %b want 1 0 0", i, wb_valid, wb_reg_write, stall); end
            end
            $display("lane %0d: we=%b size=%0d addr=%h be=%b value=%h", i, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].be, vecs[i].exp);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1; reg_write_in = 1; alu_result = 32'h11; rd_in = 1;
        step();
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h11 || wb_rd !== 5'd1) begin n_fail++; $display("FAIL b2b_first: valid %b data %h rd %0d want 1 00000011 1", wb_valid, wb_data, wb_rd); end
        alu_result = 32'h22; rd_in = 2;
        step();
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h22 || wb_rd !== 5'd2) begin n_fail++; $display("FAIL b2b_second: valid %b data %h rd %0d want 1 00000022 2", wb_valid, wb_data, wb_rd); end
        // Store, then an ALU op held upstream while stalled.
        mem_write = 1; mem_size = 2'd2; alu_result = 32'h40; store_data = 32'h0BADCAFE; rd_in = 8;
        step();
        mem_write = 0; alu_result = 32'h55; rd_in = 9; reg_write_in = 1; in_valid = 1;
        dmem_gnt = 1;
        step();
        dmem_gnt = 0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_store_beat: valid %b rw %b stall %b want 1 0 0", wb_valid, wb_reg_write, stall); end
        step();
        clear_inputs();
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h55 || wb_rd !== 5'd9 || wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL b2b_held_alu: valid %b data %h rd %0d rw %b want 1 00000055 9 1", wb_valid, wb_data, wb_rd, wb_reg_write); end
        step();
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: got %b want 0", wb_valid); end
        $display("back-to-back: alu 11, alu 22, store then held alu 55");
    endtask

    task automatic test_reset_mid_access();
        in_valid = 1; mem_read = 1; mem_size = 2'd2; alu_result = 32'h50; reg_write_in = 1; rd_in = 12;
        step();
        clear_inputs();
        n_cmp++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_pre: got %b want 1", dmem_req); end
        #2 rst = 1;
        #1;
        n_cmp++; if (dmem_req !== 1'b0 || stall !== 1'b0 || dmem_be !== 4'b0000) begin n_fail++; $display("FAIL rst_in_req: req %b stall %b be %b want 0 0 0000", dmem_req, stall, dmem_be); end
        @(negedge clk) rst = 0;
        step();
        in_valid = 1; mem_read = 1; mem_size = 2'd2; alu_result = 32'h60; reg_write_in = 1; rd_in = 13;
        step();
        clear_inputs();
        dmem_gnt = 1;
        step();
        dmem_gnt = 0;
        n_cmp++; if (stall !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_wait_pre: stall %b req %b want 1 0", stall, dmem_req); end
        #2 rst = 1;
        #1;
        n_cmp++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_in_wait: stall %b req %b want 0 0", stall, dmem_req); end
        @(negedge clk) rst = 0;
        dmem_rvalid = 1; dmem_rdata = 32'h12345678;
        step();
        dmem_rvalid = 0; dmem_rdata = 0;
        n_cmp++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid: wb_valid %b stall %b want 0 0", wb_valid, stall); end
        step();
        n_cmp++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_quiet: wb_valid %b req %b want 0 0", wb_valid, dmem_req); end
        $display("reset mid-access: REQ and WAIT aborted, late rvalid ignored");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch(1'b1, 32'h80);
        test_branch(1'b0, 32'h90);
        test_store_byte();
        test_load_half(1'b0, 32'hFFFF8001);
        test_load_half(1'b1, 32'h00008001);
        test_misaligned(1'b0, 2'd2, 32'h301);
        test_misaligned(1'b1, 2'd1, 32'h005);
        test_lanes();
        test_back_to_back();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
